// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between the bus-side writer, the UART transmitter and the TX byte FIFO.
// The slave modport is the FIFO; master is the combined bus/transmitter side.
interface uart_tx_fifo_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
);
  logic                      wr_en;
  logic [DATA_WIDTH-1:0]     wr_data;
  logic                      flush;
  logic                      rd;
  logic                      clr_err;
  logic [DATA_WIDTH-1:0]     data;
  logic                      empty;
  logic                      full;
  logic                      almost_full;
  logic [$clog2(DEPTH):0]    level;
  logic                      overflow;
  logic                      underflow;

  modport master (
    output wr_en, wr_data, flush, rd, clr_err,
    input  data, empty, full, almost_full, level, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, flush, rd, clr_err,
    output data, empty, full, almost_full, level, overflow, underflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Show-ahead byte FIFO feeding the UART transmitter, with occupancy and sticky error status.
// Pointers carry an extra wrap bit so level is a plain modular difference.
module uart_tx_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AF_LEVEL   = 12
) (
  input logic           clk,
  input logic           reset_n,
  uart_tx_fifo_if.slave bus
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;
  localparam logic [PtrW-1:0] DepthLvl = PtrW'(DEPTH);
  localparam logic [PtrW-1:0] AfLvl    = PtrW'(AF_LEVEL);

  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PtrW-1:0] level;
  logic            empty, full;
  logic            pop_ok, push_ok, ovf_evt, udf_evt;

  assign level = wr_ptr_q - rd_ptr_q;
  assign empty = (level == '0);
  assign full  = (level == DepthLvl);

  // A pop accepted this edge frees a slot, so a push into a full FIFO still lands.
  always_comb begin
    pop_ok  = 1'b0;
    push_ok = 1'b0;
    ovf_evt = 1'b0;
    udf_evt = 1'b0;
    if (!bus.flush) begin
      pop_ok  = bus.rd && !empty;
      udf_evt = bus.rd && empty;
      push_ok = bus.wr_en && (!full || pop_ok);
      ovf_evt = bus.wr_en && !push_ok;
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = ovf_evt || (overflow_q && !bus.clr_err);
    underflow_d = udf_evt || (underflow_q && !bus.clr_err);
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AddrW-1:0]] <= bus.wr_data;
  end

  assign bus.data        = empty ? '0 : mem_q[rd_ptr_q[AddrW-1:0]];
  assign bus.empty       = empty;
  assign bus.full        = full;
  assign bus.almost_full = (level >= AfLvl);
  assign bus.level       = level;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: constant vector table, directed corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_uart_tx_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 12;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic          wr;
    logic [DW-1:0] wd;
    logic          rd;
    logic          fl;
    logic          clr;
    int            lvl;
    logic          emp;
    logic [DW-1:0] dat;
    logic          ovf;
    logic          udf;
  } vec_t;

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] q[$];
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    int sz;
    sz = q.size();
    chk({tag, ".level"}, 32'(bus.level), 32'(sz));
    chk({tag, ".empty"}, 32'(bus.empty), 32'(sz == 0));
    chk({tag, ".full"}, 32'(bus.full), 32'(sz == DEPTH));
    chk({tag, ".almost_full"}, 32'(bus.almost_full), 32'(sz >= AF));
    chk({tag, ".data"}, 32'(bus.data), (sz != 0) ? 32'(q[0]) : 32'd0);
    chk({tag, ".overflow"}, 32'(bus.overflow), 32'(m_ovf));
    chk({tag, ".underflow"}, 32'(bus.underflow), 32'(m_udf));
  endtask

  task automatic model_update(input logic wr, input logic [DW-1:0] wd, input logic rd,
                              input logic fl, input logic clr);
    bit was_empty, was_full, popped, pushed, ovf_e, udf_e;
    was_empty = (q.size() == 0);
    was_full  = (q.size() == DEPTH);
    ovf_e = 0;
    udf_e = 0;
    if (fl) begin
      q.delete();
    end else begin
      popped = rd && !was_empty;
      udf_e  = rd && was_empty;
      pushed = wr && (!was_full || popped);
      ovf_e  = wr && !pushed;
      if (popped) void'(q.pop_front());
      if (pushed) q.push_back(wd);
    end
    m_ovf = ovf_e || (m_ovf && !clr);
    m_udf = udf_e || (m_udf && !clr);
  endtask

  task automatic step(input logic wr, input logic [DW-1:0] wd, input logic rd,
                      input logic fl, input logic clr, input string tag);
    bus.wr_en   = wr;
    bus.wr_data = wd;
    bus.rd      = rd;
    bus.flush   = fl;
    bus.clr_err = clr;
    @(posedge clk);
    model_update(wr, wd, rd, fl, clr);
    #1;
    bus.wr_en   = 1'b0;
    bus.rd      = 1'b0;
    bus.flush   = 1'b0;
    bus.clr_err = 1'b0;
    check_model(tag);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".level"}, 32'(bus.level), 32'd0);
    chk({tag, ".empty"}, 32'(bus.empty), 32'd1);
    chk({tag, ".full"}, 32'(bus.full), 32'd0);
    chk({tag, ".almost_full"}, 32'(bus.almost_full), 32'd0);
    chk({tag, ".data"}, 32'(bus.data), 32'd0);
    chk({tag, ".overflow"}, 32'(bus.overflow), 32'd0);
    chk({tag, ".underflow"}, 32'(bus.underflow), 32'd0);
  endtask

  vec_t tbl[$];

  initial begin
    // wr, wd, rd, fl, clr | lvl, emp, dat, ovf, udf
    tbl.push_back(vec_t'{1, 8'hA5, 0, 0, 0, 1, 0, 8'hA5, 0, 0});
    tbl.push_back(vec_t'{0, 8'h00, 1, 0, 0, 0, 1, 8'h00, 0, 0});
    tbl.push_back(vec_t'{1, 8'h3C, 1, 0, 0, 1, 0, 8'h3C, 0, 1});
    tbl.push_back(vec_t'{0, 8'h00, 0, 0, 1, 1, 0, 8'h3C, 0, 0});
    tbl.push_back(vec_t'{0, 8'h00, 1, 0, 0, 0, 1, 8'h00, 0, 0});
    tbl.push_back(vec_t'{0, 8'h00, 1, 0, 0, 0, 1, 8'h00, 0, 1});
    tbl.push_back(vec_t'{0, 8'h00, 1, 0, 1, 0, 1, 8'h00, 0, 1}); // set beats clear
    tbl.push_back(vec_t'{0, 8'h00, 0, 0, 1, 0, 1, 8'h00, 0, 0});
    tbl.push_back(vec_t'{1, 8'h11, 0, 0, 0, 1, 0, 8'h11, 0, 0});
    tbl.push_back(vec_t'{1, 8'h22, 0, 0, 0, 2, 0, 8'h11, 0, 0});
    tbl.push_back(vec_t'{1, 8'h33, 1, 0, 0, 2, 0, 8'h22, 0, 0});
    tbl.push_back(vec_t'{1, 8'h44, 1, 1, 0, 0, 1, 8'h00, 0, 0}); // flush wins
    tbl.push_back(vec_t'{1, 8'h77, 0, 0, 0, 1, 0, 8'h77, 0, 0});
    tbl.push_back(vec_t'{0, 8'h00, 1, 0, 0, 0, 1, 8'h00, 0, 0});

    reset_n     = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd      = 1'b0;
    bus.flush   = 1'b0;
    bus.clr_err = 1'b0;
    #12;
    chk_reset_state("reset");
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].wr, tbl[i].wd, tbl[i].rd, tbl[i].fl, tbl[i].clr, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.exp_level", i), 32'(bus.level), 32'(tbl[i].lvl));
      chk($sformatf("tbl%0d.exp_empty", i), 32'(bus.empty), 32'(tbl[i].emp));
      chk($sformatf("tbl%0d.exp_data", i), 32'(bus.data), 32'(tbl[i].dat));
      chk($sformatf("tbl%0d.exp_ovf", i), 32'(bus.overflow), 32'(tbl[i].ovf));
      chk($sformatf("tbl%0d.exp_udf", i), 32'(bus.underflow), 32'(tbl[i].udf));
    end

    // Fill to full, overflow, drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, DW'(i), 1'b0, 1'b0, 1'b0, "fill");
      if (i == AF - 2) chk("af_before", 32'(bus.almost_full), 32'd0);
      if (i == AF - 1) chk("af_rise", 32'(bus.almost_full), 32'd1);
    end
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_level", 32'(bus.level), 32'd16);
    step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, "push17");
    chk("push17_ovf", 32'(bus.overflow), 32'd1);
    chk("push17_level", 32'(bus.level), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_order", 32'(bus.data), 32'(i));
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "drain");
    end
    chk("drain_empty", 32'(bus.empty), 32'd1);

    // Full FIFO with simultaneous push and pop.
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "clr");
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(i), 1'b0, 1'b0, 1'b0, "refill");
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, "full_rw");
    chk("full_rw_full", 32'(bus.full), 32'd1);
    chk("full_rw_level", 32'(bus.level), 32'd16);
    chk("full_rw_ovf", 32'(bus.overflow), 32'd0);
    chk("full_rw_head", 32'(bus.data), 32'h01);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("full_rw_last", 32'(bus.data), 32'h55);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "full_rw_drain");
    end

    // Flush at level 5, then wrap the pointers with push/pop pairs.
    for (int i = 0; i < 5; i++) step(1'b1, DW'(8'hC0 + i), 1'b0, 1'b0, 1'b0, "lvl5");
    step(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0, "flush");
    chk("flush_level", 32'(bus.level), 32'd0);
    chk("flush_empty", 32'(bus.empty), 32'd1);
    chk("flush_flags", 32'({bus.overflow, bus.underflow}), 32'd0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, DW'(8'h80 + i), 1'b0, 1'b0, 1'b0, "pair_push");
      chk("pair_data", 32'(bus.data), 32'(8'h80 + i));
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "pair_pop");
      chk("pair_level", 32'(bus.level <= 1), 32'd1);
    end

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(99) < 60), DW'($urandom), ($urandom_range(99) < 50),
           ($urandom_range(99) < 3), ($urandom_range(99) < 5), "rand");
    end

    // Asynchronous reset between edges at level 7.
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "pre_rst_flush");
    for (int i = 0; i < 7; i++) step(1'b1, DW'(8'h60 + i), 1'b0, 1'b0, 1'b0, "lvl7");
    chk("lvl7_level", 32'(bus.level), 32'd7);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_state("async_rst");
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 8'h9A, 1'b0, 1'b0, 1'b0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
